fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline: holds the program counter, presents it to instruction memory, and latches the returned word into the IF/ID pipeline register consumed by decode. It sits directly upstream of the decode/extend/branch logic and consumes the redirect targets that logic produces. Branch and jump targets arrive as full 32-bit addresses. The block handles stall, flush-on-redirect, a halt word, and a fetched-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- CLK  input  1  single clock; all state changes on rising edge
- RESETn  input  1  asynchronous, active-low reset
- stall  input  1  hold PC and IF/ID contents this cycle
- branch_taken  input  1  redirect to branch_target; flush the word being fetched
- branch_target  input  32  branch destination
- jump  input  1  redirect to jump_target; flush the word being fetched
- jump_target  input  32  jump destination
- imem_data  input  32  combinational instruction-memory read data for address pc
- pc  output  32  current fetch address to instruction memory
- if_id_instr  output  32  latched instruction; 0 when bubble
- if_id_pc4  output  32  address of latched instruction + 4
- if_id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  high in HALTED state
- fetch_count  output  32  number of valid instructions latched into IF/ID

## Operation
- States: BOOT, RUN, HALTED. Reset enters BOOT.
- BOOT: lasts one cycle after RESETn deasserts. pc = RESET_PC, and the IF/ID register receives a bubble. The block then goes to RUN. Inputs are ignored.
- RUN, per-edge priority, highest first:
  1. jump: pc <- jump_target; IF/ID <- bubble.
  2. branch_taken: pc <- branch_target; IF/ID <- bubble.
  3. stall: pc, IF/ID and fetch_count all hold.
  4. imem_data == HALT_WORD: IF/ID <- {imem_data, pc+4, valid=1}; pc holds; fetch_count increments; go to HALTED.
  5. Otherwise: IF/ID <- {imem_data, pc+4, valid=1}; pc <- pc+4; fetch_count increments.
- Redirect beats stall. The stalled instruction is on the wrong path, so it is replaced by a bubble.
- HALTED: pc holds and IF/ID receives a bubble every cycle.
  - jump or branch_taken in HALTED means the halt word was on the wrong path. pc <- target, IF/ID <- bubble, and the state returns to RUN.
  - stall in HALTED has no effect.
- halted = 1 in HALTED only.
- Bubble encoding: if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0.
- Arithmetic:
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Redirect targets are loaded with bits [1:0] forced to 00.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values (asserted asynchronously): pc = RESET_PC, IF/ID = bubble, halted = 0, fetch_count = 0, state = BOOT.
- Reset mid-operation discards all state immediately. No partial update occurs on the next edge.
- Instruction memory is combinational. The word at pc is sampled on the same edge that advances pc.
- Fetch-to-decode latency is 1 cycle: the word at pc appears on if_id_instr after the next rising edge.
- Redirect latency is 1 cycle. The edge that samples jump or branch_taken loads the target into pc. The following edge latches the target instruction.
- Throughput is one instruction per cycle in RUN when stall, jump and branch_taken are all 0.
- jump and branch_taken asserted together: jump wins.

## Test plan
- Sequential fetch: reset with RESET_PC = 0, then release.
  - Cycle 1 is a BOOT bubble.
  - imem returns 32'h2008_0005 at pc 0 -> after the next edge, if_id_instr = 32'h2008_0005, if_id_pc4 = 4, pc = 4, fetch_count = 1.
- Stall: assert stall for 3 cycles with pc = 8 -> pc stays 8, IF/ID unchanged, fetch_count unchanged. Deassert -> resumes at 8.
- Redirect priority:
  - At pc = 12, branch_taken with target 32'h40 -> pc = 32'h40, if_id_valid = 0.
  - jump (target 32'h100) together with branch_taken (target 32'h40) -> pc = 32'h100.
  - stall together with branch_taken -> redirect still taken.
- Halt: imem returns 32'hFFFF_FFFF at pc = 32'h20.
  - halted = 1, pc stays 32'h20, and the halt word is latched valid once. Bubbles follow, and fetch_count stops.
  - A later jump to 32'h80 -> halted = 0, pc = 32'h80.
- Wrap and alignment:
  - pc = 32'hFFFF_FFFC sequential -> pc = 0, if_id_pc4 = 0.
  - jump_target = 32'h0000_0013 -> pc = 32'h0000_0010.
- Async reset: drop RESETn between edges while in RUN at pc = 32'h44 -> pc = RESET_PC and if_id_valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the MIPS pipeline. Holds the program counter,
// presents it to a combinational instruction memory and latches the returned
// word into the IF/ID pipeline register for decode. Handles stall, flush on
// branch/jump redirect, a halt word that freezes fetch, and a count of the
// valid instructions latched.
//
// Ports
//   CLK            in   1   rising-edge clock
//   RESETn         in   1   asynchronous active-low reset
//   stall          in   1   hold pc, IF/ID and fetch_count
//   branch_taken   in   1   redirect to branch_target, flush fetched word
//   branch_target  in  32   branch destination (bits [1:0] ignored)
//   jump           in   1   redirect to jump_target, flush fetched word (beats branch)
//   jump_target    in  32   jump destination (bits [1:0] ignored)
//   imem_data      in  32   instruction word at address pc
//   pc             out 32   current fetch address
//   if_id_instr    out 32   latched instruction, 0 for a bubble
//   if_id_pc4      out 32   latched instruction address + 4, 0 for a bubble
//   if_id_valid    out  1   IF/ID holds a real instruction
//   halted         out  1   fetch is stopped on a halt word
//   fetch_count    out 32   valid instructions latched (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_nx;
    logic [31:0] instr_nx;
    logic [31:0] pc4_nx;
    logic        valid_nx;
    logic [31:0] count_nx;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        redirect;

    assign pc_plus4    = pc + 32'd4;  // modulo 2^32 by width
    // Jump wins over branch when both are asserted; targets are word-aligned.
    assign redirect    = jump | branch_taken;
    assign redirect_pc = jump ? {jump_target[31:2], 2'b00}
                              : {branch_target[31:2], 2'b00};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nx = state;
        pc_nx    = pc;
        instr_nx = if_id_instr;
        pc4_nx   = if_id_pc4;
        valid_nx = if_id_valid;
        count_nx = fetch_count;

        unique case (state)
            BOOT: begin
                pc_nx    = RESET_PC;
                instr_nx = '0;
                pc4_nx   = '0;
                valid_nx = 1'b0;
                state_nx = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Redirect beats stall: the held word is on the wrong path.
                    pc_nx    = redirect_pc;
                    instr_nx = '0;
                    pc4_nx   = '0;
                    valid_nx = 1'b0;
                end else if (!stall) begin
                    instr_nx = imem_data;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                    count_nx = fetch_count + 32'd1;
                    if (imem_data == HALT_WORD) begin
                        state_nx = HALTED;   // pc stays on the halt word
                    end else begin
                        pc_nx = pc_plus4;
                    end
                end
            end
            HALTED: begin
                instr_nx = '0;
                pc4_nx   = '0;
                valid_nx = 1'b0;
                if (redirect) begin
                    // The halt word was fetched down a mispredicted path.
                    pc_nx    = redirect_pc;
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            if_id_instr <= instr_nx;
            if_id_pc4   <= pc4_nx;
            if_id_valid <= valid_nx;
            fetch_count <= count_nx;
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. Directed per-cycle stimulus pushes the
// hand-computed post-edge state into a queue; a monitor process pops one
// entry one time unit after each rising edge and compares all outputs.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];

    fetch_stage dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_data     (imem_data),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 CLK = ~CLK;

    // Instruction memory model: a few fixed words, a halt word at 0x20, and
    // {16'h3400, addr[15:0]} everywhere else.
    always_comb begin
        imem_data = {16'h3400, pc[15:0]};
        case (pc)
            32'h0000_0000: imem_data = 32'h2008_0005;
            32'h0000_0004: imem_data = 32'h2009_0006;
            32'h0000_0008: imem_data = 32'h200A_0007;
            32'h0000_0020: imem_data = 32'hFFFF_FFFF;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs after every edge that has an expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".pc"},     pc,                  e.pc);
            check({e.tag, ".instr"},  if_id_instr,         e.instr);
            check({e.tag, ".pc4"},    if_id_pc4,           e.pc4);
            check({e.tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, e.valid});
            check({e.tag, ".halted"}, {31'd0, halted},      {31'd0, e.halted});
            check({e.tag, ".count"},  fetch_count,         e.count);
        end
    end

    // Drive one cycle of inputs and queue the expected state after the edge.
    task automatic step(input string tag,
                        input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt,
                        input logic s,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid,
                        input logic e_halted, input logic [31:0] e_count);
        exp_t e;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        stall         = s;
        e.tag = tag; e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4;
        e.valid = e_valid; e.halted = e_halted; e.count = e_count;
        exp_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc"},     pc,                    32'h0);
        check({tag, ".instr"},  if_id_instr,           32'h0);
        check({tag, ".pc4"},    if_id_pc4,             32'h0);
        check({tag, ".valid"},  {31'd0, if_id_valid},  32'h0);
        check({tag, ".halted"}, {31'd0, halted},       32'h0);
        check({tag, ".count"},  fetch_count,           32'h0);
    endtask

    initial begin
        #2;
        check_reset_state("reset");
        repeat (2) @(posedge CLK);
        #2;
        RESETn = 1'b1;

        //    tag          j  jt            b  bt            s   pc            instr         pc4           v  h  cnt
        step("boot",       0, 32'h0,        0, 32'h0,        0,  32'h0,        32'h0,        32'h0,        0, 0, 32'd0);
        step("seq0",       0, 32'h0,        0, 32'h0,        0,  32'h4,        32'h2008_0005, 32'h4,       1, 0, 32'd1);
        step("seq4",       0, 32'h0,        0, 32'h0,        0,  32'h8,        32'h2009_0006, 32'h8,       1, 0, 32'd2);
        for (int i = 0; i < 3; i++)
            step("stall",  0, 32'h0,        0, 32'h0,        1,  32'h8,        32'h2009_0006, 32'h8,       1, 0, 32'd2);
        step("resume",     0, 32'h0,        0, 32'h0,        0,  32'hC,        32'h200A_0007, 32'hC,       1, 0, 32'd3);
        step("branch",     0, 32'h0,        1, 32'h40,       0,  32'h40,       32'h0,        32'h0,        0, 0, 32'd3);
        step("seq40",      0, 32'h0,        0, 32'h0,        0,  32'h44,       32'h3400_0040, 32'h44,      1, 0, 32'd4);
        step("jmp_vs_br",  1, 32'h100,      1, 32'h40,       0,  32'h100,      32'h0,        32'h0,        0, 0, 32'd4);
        step("br_vs_stl",  0, 32'h0,        1, 32'h18,       1,  32'h18,       32'h0,        32'h0,        0, 0, 32'd4);
        step("seq18",      0, 32'h0,        0, 32'h0,        0,  32'h1C,       32'h3400_0018, 32'h1C,      1, 0, 32'd5);
        step("seq1c",      0, 32'h0,        0, 32'h0,        0,  32'h20,       32'h3400_001C, 32'h20,      1, 0, 32'd6);
        step("halt",       0, 32'h0,        0, 32'h0,        0,  32'h20,       32'hFFFF_FFFF, 32'h24,      1, 1, 32'd7);
        step("halted1",    0, 32'h0,        0, 32'h0,        0,  32'h20,       32'h0,        32'h0,        0, 1, 32'd7);
        step("halt_stl",   0, 32'h0,        0, 32'h0,        1,  32'h20,       32'h0,        32'h0,        0, 1, 32'd7);
        step("unhalt",     1, 32'h80,       0, 32'h0,        0,  32'h80,       32'h0,        32'h0,        0, 0, 32'd7);
        step("seq80",      0, 32'h0,        0, 32'h0,        0,  32'h84,       32'h3400_0080, 32'h84,      1, 0, 32'd8);
        step("jmp_top",    1, 32'hFFFF_FFFC, 0, 32'h0,       0,  32'hFFFF_FFFC, 32'h0,       32'h0,        0, 0, 32'd8);
        step("wrap",       0, 32'h0,        0, 32'h0,        0,  32'h0,        32'h3400_FFFC, 32'h0,       1, 0, 32'd9);
        step("after_wrap", 0, 32'h0,        0, 32'h0,        0,  32'h4,        32'h2008_0005, 32'h4,       1, 0, 32'd10);
        step("jmp_align",  1, 32'h13,       0, 32'h0,        0,  32'h10,       32'h0,        32'h0,        0, 0, 32'd10);
        step("seq10",      0, 32'h0,        0, 32'h0,        0,  32'h14,       32'h3400_0010, 32'h14,      1, 0, 32'd11);
        step("br_align",   0, 32'h0,        1, 32'h43,       0,  32'h40,       32'h0,        32'h0,        0, 0, 32'd11);
        step("seq40b",     0, 32'h0,        0, 32'h0,        0,  32'h44,       32'h3400_0040, 32'h44,      1, 0, 32'd12);

        // Asynchronous reset between edges while running at pc = 0x44.
        #1;
        RESETn = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge CLK);
        #2;
        check_reset_state("rst_held");
        RESETn = 1'b1;
        step("boot2",      0, 32'h0,        0, 32'h0,        0,  32'h0,        32'h0,        32'h0,        0, 0, 32'd0);
        step("seq0b",      0, 32'h0,        0, 32'h0,        0,  32'h4,        32'h2008_0005, 32'h4,       1, 0, 32'd1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
